cache_port_arbiter: RTL

//  Shares one cache_data instance between two requesters (port 0, port 1; e.g. fetch and load/store).

---
 rtl/cache_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cache_port_arbiter.sv
// ============================================================================
//  Module      : cache_port_arbiter
//  Description : Round-robin two-port front end sharing one cache_data instance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_port_arbiter #(
    parameter int PA_WIDTH  = 32,
    parameter int WRD_WIDTH = 32,
    parameter int BYTE_W    = 8,
    parameter int TMO_CYC   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [PA_WIDTH-1:0]  addr0,
    input  logic [PA_WIDTH-1:0]  addr1,
    input  logic [WRD_WIDTH-1:0] wdata0,
    input  logic [WRD_WIDTH-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 err0,
    output logic                 err1,
    output logic [WRD_WIDTH-1:0] rd_word,
    output logic [BYTE_W-1:0]    rd_byte,
    output logic                 rd_hit,
    output logic                 busy,
    output logic                 c_rd_en,
    output logic                 c_wr_en,
    output logic [PA_WIDTH-1:0]  c_addr,
    output logic [WRD_WIDTH-1:0] c_data_wr,
    input  logic                 c_hit,
    input  logic [WRD_WIDTH-1:0] c_word,
    input  logic [BYTE_W-1:0]    c_byte,
    input  logic                 c_rdy
);

    localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [CW-1:0] c_tmo_last = CW'(TMO_CYC - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_issue = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_done  = 3'd3;
    localparam logic [2:0] c_st_abort = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic          r_rr_ptr;
    logic          r_gnt;
    logic          r_we;
    logic          r_rdy_q;
    logic [CW-1:0] r_tmo_cnt;
    logic          w_cmp;
    logic          w_any_req;
    logic          w_sel;

    // Only a rising rdy completes an access; a level left high from before is ignored.
    assign w_cmp     = c_rdy & ~r_rdy_q;
    assign w_any_req = req0 | req1;
    assign w_sel     = (req0 & req1) ? r_rr_ptr : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (w_any_req) w_next = c_st_issue;
            c_st_issue: w_next = c_st_wait;
            c_st_wait: begin
                if (w_cmp)                        w_next = c_st_done;
                else if (r_tmo_cnt == c_tmo_last) w_next = c_st_abort;
            end
            c_st_done:  w_next = c_st_idle;
            c_st_abort: w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= 1'b0;
            r_gnt     <= 1'b0;
            r_we      <= 1'b0;
            r_rdy_q   <= 1'b0;
            r_tmo_cnt <= '0;
            c_addr    <= '0;
            c_data_wr <= '0;
            rd_word   <= '0;
            rd_byte   <= '0;
            rd_hit    <= 1'b0;
        end else begin
            r_rdy_q <= c_rdy;
            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        r_gnt     <= w_sel;
                        r_we      <= w_sel ? we1 : we0;
                        c_addr    <= w_sel ? addr1 : addr0;
                        c_data_wr <= w_sel ? wdata1 : wdata0;
                    end
                end
                c_st_issue: r_tmo_cnt <= '0;
                c_st_wait: begin
                    if (w_cmp) begin
                        rd_word <= c_word;
                        rd_byte <= c_byte;
                        rd_hit  <= c_hit;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                c_st_done, c_st_abort: r_rr_ptr <= ~r_gnt;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy    = (r_state != c_st_idle);
        c_rd_en = ((r_state == c_st_issue) || (r_state == c_st_wait)) & ~r_we;
        c_wr_en = ((r_state == c_st_issue) || (r_state == c_st_wait)) &  r_we;
        ack0    = (r_state == c_st_done)  & ~r_gnt;
        ack1    = (r_state == c_st_done)  &  r_gnt;
        err0    = (r_state == c_st_abort) & ~r_gnt;
        err1    = (r_state == c_st_abort) &  r_gnt;
    end

endmodule

`default_nettype wire
